// File: rtl/incrementer_pkg.sv
// Shared definitions for the incrementer timer: FSM state encoding and default width.
package incrementer_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/inc_datapath.sv
// Count register with +1 adder and the two limit comparators used by the FSM.
module inc_datapath
  import incrementer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             at_limit,
  output logic             last_step
);

  // One extra bit so count+1 can be compared against an all-ones limit without wrapping.
  logic [WIDTH:0] count_plus;

  assign count_plus = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count_plus[WIDTH-1:0];
    end
  end

  assign at_limit  = (count == limit);
  assign last_step = (count_plus == {1'b0, limit});

endmodule

// File: rtl/incrementer_timer.sv
// Count-up timer: counts increments from 0 to a loaded limit, pulsing done on arrival.
//
// state | meaning
// IDLE  | no run active; count held
// RUN   | counting increments toward the limit
// DONE  | count parked at the limit until load, start or abort
module incrementer_timer
  import incrementer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] limit_value,
  input  logic             start,
  input  logic             increment,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             at_limit,
  output logic             err
);

  state_t           state_q, state_next;
  logic [WIDTH-1:0] limit_q, limit_next;
  logic             err_q, err_next;
  logic             done_q, done_next;
  logic             cnt_clr, cnt_inc;
  logic             last_step;

  inc_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
    .limit     (limit_q),
    .count     (count),
    .at_limit  (at_limit),
    .last_step (last_step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      limit_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_next;
      limit_q <= limit_next;
      err_q   <= err_next;
      done_q  <= done_next;
    end
  end

  // Priority: load > abort > start > increment; reset is handled in the register block.
  always_comb begin
    state_next = state_q;
    limit_next = limit_q;
    err_next   = err_q;
    done_next  = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    if (load) begin
      limit_next = limit_value;
      cnt_clr    = 1'b1;
      err_next   = 1'b0;
      state_next = IDLE;
    end else if (abort) begin
      state_next = IDLE;
    end else if (start) begin
      cnt_clr = 1'b1;
      if (limit_q == '0) begin
        state_next = DONE;
        done_next  = 1'b1;
      end else begin
        state_next = RUN;
      end
    end else if (increment) begin
      case (state_q)
        RUN: begin
          cnt_inc = 1'b1;
          if (last_step) begin
            state_next = DONE;
            done_next  = 1'b1;
          end
        end
        default: err_next = 1'b1;
      endcase
    end
    if (state_q != IDLE && state_q != RUN && state_q != DONE) begin
      state_next = IDLE;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_incrementer_timer.sv
// Self-checking bench for incrementer_timer: directed scenarios plus random traffic vs. a rule-level model.
module tb_incrementer_timer;

  localparam int W = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic         clk = 1'b0;
  logic         reset, load, start, increment, abort;
  logic [W-1:0] limit_value;
  logic [W-1:0] count;
  logic         busy, done, at_limit, err;

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;

  int m_mode, m_count, m_limit, m_err, m_done;

  incrementer_timer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .limit_value (limit_value),
    .start       (start),
    .increment   (increment),
    .abort       (abort),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .at_limit    (at_limit),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference behaviour expressed directly from the rules, one clock at a time.
  task automatic model_step(input bit r, input bit l, input int lv, input bit s, input bit a, input bit i);
    m_done = 0;
    if (r) begin
      m_mode = M_IDLE; m_count = 0; m_limit = 0; m_err = 0;
    end else if (l) begin
      m_limit = lv; m_count = 0; m_err = 0; m_mode = M_IDLE;
    end else if (a) begin
      m_mode = M_IDLE;
    end else if (s) begin
      m_count = 0;
      if (m_limit == 0) begin
        m_mode = M_DONE; m_done = 1;
      end else begin
        m_mode = M_RUN;
      end
    end else if (i) begin
      if (m_mode == M_RUN) begin
        m_count = m_count + 1;
        if (m_count == m_limit) begin
          m_mode = M_DONE; m_done = 1;
        end
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic tick(input bit r, input bit l, input int lv, input bit s, input bit a, input bit i);
    reset = r; load = l; limit_value = W'(lv); start = s; abort = a; increment = i;
    @(posedge clk);
    model_step(r, l, lv, s, a, i);
    #1;
    if (done) done_seen++;
    chk("count",    int'(count),     m_count);
    chk("busy",     int'(busy),      (m_mode == M_RUN) ? 1 : 0);
    chk("done",     int'(done),      m_done);
    chk("at_limit", int'(at_limit),  (m_count == m_limit) ? 1 : 0);
    chk("err",      int'(err),       m_err);
    chk("state",    int'(dut.state_q), m_mode);
  endtask

  task automatic idle_tick();
    tick(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_mode = M_IDLE; m_count = 0; m_limit = 0; m_err = 0; m_done = 0;
    reset = 1'b1; load = 1'b0; limit_value = '0; start = 1'b0; abort = 1'b0; increment = 1'b0;

    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    chk("rst_count", int'(count), 0);
    chk("rst_at_limit", int'(at_limit), 1);
    chk("rst_busy", int'(busy), 0);

    // limit 3, three increments
    tick(0, 1, 3, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    done_seen = 0;
    for (int k = 1; k <= 3; k++) begin
      tick(0, 0, 0, 0, 0, 1);
      chk("l3_count", int'(count), k);
    end
    chk("l3_done_now", int'(done), 1);
    idle_tick();
    chk("l3_done_once", done_seen, 1);
    chk("l3_state", int'(dut.state_q), M_DONE);
    chk("l3_busy", int'(busy), 0);

    // limit 0 goes straight to DONE
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    chk("l0_done", int'(done), 1);
    chk("l0_state", int'(dut.state_q), M_DONE);
    chk("l0_count", int'(count), 0);
    idle_tick();
    chk("l0_done_off", int'(done), 0);

    // limit 15: full range, no wrap
    tick(0, 1, 15, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 15; k++) tick(0, 0, 0, 0, 0, 1);
    chk("l15_count", int'(count), 15);
    chk("l15_done", int'(done), 1);
    tick(0, 0, 0, 0, 0, 1);
    chk("l15_hold", int'(count), 15);
    chk("l15_err", int'(err), 1);

    // abort with coincident increment
    tick(0, 1, 5, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1, 1);
    chk("ab_state", int'(dut.state_q), M_IDLE);
    chk("ab_count", int'(count), 2);
    chk("ab_err", int'(err), 0);
    tick(0, 0, 0, 0, 0, 1);
    chk("ab_err_set", int'(err), 1);
    tick(0, 1, 5, 0, 0, 0);
    chk("ab_err_clr", int'(err), 0);

    // reset mid-run
    tick(0, 1, 4, 0, 0, 0);
    done_seen = 0;
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0);
    chk("rr_count", int'(count), 0);
    chk("rr_state", int'(dut.state_q), M_IDLE);
    idle_tick();
    chk("rr_no_done", done_seen, 0);

    // restart with coincident increment
    tick(0, 1, 4, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 1, 0, 1);
    chk("rs_count", int'(count), 0);
    chk("rs_state", int'(dut.state_q), M_RUN);
    chk("rs_err", int'(err), 0);

    // random traffic, increment-heavy so runs regularly complete
    for (int n = 0; n < 600; n++) begin
      int p;
      bit r, l, s, a, i;
      int lv;
      p  = int'($urandom_range(0, 99));
      r  = (p < 2);
      l  = ($urandom_range(0, 99) < 6);
      s  = ($urandom_range(0, 99) < 10);
      a  = ($urandom_range(0, 99) < 5);
      i  = ($urandom_range(0, 99) < 65);
      lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 5));
      tick(r, l, lv, s, a, i);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
